// File: rtl/ycrcb_block_buffer.sv
// Raster-to-8x8-block reorder buffer: two ping-pong 8-row strip banks feeding a backpressured output.
// Build macro LEVEL_SHIFT_EN: each output byte is level-shifted by -128 (MSB inverted).
module ycrcb_block_buffer #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [23:0] data_in,
    output logic        ready,
    input  logic        out_ready,
    output logic [23:0] data_out,
    output logic        enable_out,
    output logic        block_start,
    output logic        frame_end
);
    localparam int BLK_COLS = IMG_WIDTH / 8;
    localparam int STRIPS   = IMG_HEIGHT / 8;
    localparam int DEPTH    = 8 * IMG_WIDTH;
    localparam int ADDR_W   = $clog2(DEPTH);
    localparam int COL_W    = $clog2(IMG_WIDTH);
    localparam int BX_W     = (BLK_COLS > 1) ? $clog2(BLK_COLS) : 1;
    localparam int ST_W     = (STRIPS > 1) ? $clog2(STRIPS) : 1;

`ifdef LEVEL_SHIFT_EN
    localparam logic [23:0] OUT_XOR = 24'h808080;
`else
    localparam logic [23:0] OUT_XOR = 24'h000000;
`endif

    typedef enum logic {R_IDLE, R_DRAIN} rd_state_t;

    logic              r_wr_bank;
    logic [COL_W-1:0]  r_wcol;
    logic [2:0]        r_wrow;
    logic              w_accept;
    logic              w_wr_last;
    logic [ADDR_W-1:0] w_waddr;

    rd_state_t         r_state;
    rd_state_t         w_state_nxt;
    logic              r_iss_bank;
    logic [BX_W-1:0]   r_bx;
    logic [2:0]        r_r;
    logic [2:0]        r_c;
    logic [ST_W-1:0]   r_strip;
    logic              w_issue;
    logic              w_iss_last;
    logic              w_iss_bs;
    logic              w_iss_fe;
    logic [ADDR_W-1:0] w_raddr;

    logic              r_rd_bank;
    logic [1:0]        r_bank_full;
    logic [1:0]        w_bank_full_nxt;
    logic              w_rd_done;

    logic              r_m_valid;
    logic              r_m_bs;
    logic              r_m_fe;
    logic              r_m_last;
    logic [23:0]       r_m_data;
    logic              r_o_valid;
    logic              r_o_bs;
    logic              r_o_fe;
    logic              r_o_last;
    logic [23:0]       r_o_data;
    logic              w_out_adv;
    logic              w_m_adv;

    logic [23:0]       r_mem [2][DEPTH];

    assign ready     = ~r_bank_full[r_wr_bank];
    assign w_accept  = enable & ready;
    assign w_wr_last = (r_wrow == 3'd7) && (r_wcol == COL_W'(IMG_WIDTH - 1));
    assign w_waddr   = ADDR_W'(r_wrow) * ADDR_W'(IMG_WIDTH) + ADDR_W'(r_wcol);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wcol    <= '0;
            r_wrow    <= '0;
            r_wr_bank <= 1'b0;
        end else if (w_accept) begin
            if (r_wcol == COL_W'(IMG_WIDTH - 1)) begin
                r_wcol <= '0;
                r_wrow <= r_wrow + 3'd1;
                if (w_wr_last) r_wr_bank <= ~r_wr_bank;
            end else begin
                r_wcol <= r_wcol + COL_W'(1);
            end
        end
    end

    // Reads are issued from r_iss_bank, which may already point at the next full
    // bank while the previous strip's tail is still in the output pipeline; that
    // tail's downstream acceptance is what frees r_rd_bank.
    assign w_iss_last = (r_c == 3'd7) && (r_r == 3'd7) && (r_bx == BX_W'(BLK_COLS - 1));
    assign w_iss_bs   = (r_r == 3'd0) && (r_c == 3'd0);
    assign w_iss_fe   = w_iss_last && (r_strip == ST_W'(STRIPS - 1));
    assign w_raddr    = ADDR_W'(r_r) * ADDR_W'(IMG_WIDTH) + (ADDR_W'(r_bx) << 3) + ADDR_W'(r_c);

    assign w_out_adv  = ~r_o_valid | out_ready;
    assign w_m_adv    = ~r_m_valid | w_out_adv;

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (r_bank_full[r_iss_bank]) begin
                    w_issue     = w_m_adv;
                    w_state_nxt = R_DRAIN;
                end
            end
            R_DRAIN: begin
                w_issue = w_m_adv;
                if (w_m_adv && w_iss_last) w_state_nxt = R_IDLE;
            end
            default: w_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= R_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_c        <= '0;
            r_r        <= '0;
            r_bx       <= '0;
            r_strip    <= '0;
            r_iss_bank <= 1'b0;
        end else if (w_issue) begin
            r_c <= r_c + 3'd1;
            if (r_c == 3'd7) begin
                r_r <= r_r + 3'd1;
                if (r_r == 3'd7) begin
                    if (w_iss_last) begin
                        r_bx       <= '0;
                        r_iss_bank <= ~r_iss_bank;
                        r_strip    <= (r_strip == ST_W'(STRIPS - 1)) ? '0 : r_strip + ST_W'(1);
                    end else begin
                        r_bx <= r_bx + BX_W'(1);
                    end
                end
            end
        end
    end

    assign w_rd_done = r_o_valid & out_ready & r_o_last;

    always_comb begin
        w_bank_full_nxt = r_bank_full;
        if (w_accept && w_wr_last) w_bank_full_nxt[r_wr_bank] = 1'b1;
        if (w_rd_done)             w_bank_full_nxt[r_rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bank_full <= '0;
            r_rd_bank   <= 1'b0;
        end else begin
            r_bank_full <= w_bank_full_nxt;
            if (w_rd_done) r_rd_bank <= ~r_rd_bank;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wr_bank][w_waddr] <= data_in;
        if (w_issue)  r_m_data <= r_mem[r_iss_bank][w_raddr];
    end

    // Two registered stages (memory read, output) advance independently so a
    // stalled output never loses the beat already fetched from memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_valid <= 1'b0;
            r_m_bs    <= 1'b0;
            r_m_fe    <= 1'b0;
            r_m_last  <= 1'b0;
            r_o_valid <= 1'b0;
            r_o_bs    <= 1'b0;
            r_o_fe    <= 1'b0;
            r_o_last  <= 1'b0;
            r_o_data  <= '0;
        end else begin
            if (w_m_adv) begin
                r_m_valid <= w_issue;
                r_m_bs    <= w_issue & w_iss_bs;
                r_m_fe    <= w_issue & w_iss_fe;
                r_m_last  <= w_issue & w_iss_last;
            end
            if (w_out_adv) begin
                r_o_valid <= r_m_valid;
                r_o_bs    <= r_m_valid & r_m_bs;
                r_o_fe    <= r_m_valid & r_m_fe;
                r_o_last  <= r_m_valid & r_m_last;
                if (r_m_valid) r_o_data <= r_m_data ^ OUT_XOR;
            end
        end
    end

    assign data_out    = r_o_data;
    assign enable_out  = r_o_valid;
    assign block_start = r_o_bs;
    assign frame_end   = r_o_fe;

endmodule

// File: tb/tb_ycrcb_block_buffer.sv
// Directed scoreboard bench for ycrcb_block_buffer on a 16x16 frame (two strips).
module tb_ycrcb_block_buffer;
    localparam int W    = 16;
    localparam int H    = 16;
    localparam int NPIX = W * H;
    localparam int SPIX = 8 * W;
`ifdef LEVEL_SHIFT_EN
    localparam logic [23:0] LVL_EXP = 24'h80007F;
`else
    localparam logic [23:0] LVL_EXP = 24'h0080FF;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [23:0] data_in;
    logic        ready;
    logic        out_ready;
    logic [23:0] data_out;
    logic        enable_out;
    logic        block_start;
    logic        frame_end;

    always #5 clk = ~clk;

    ycrcb_block_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .enable(enable), .data_in(data_in), .ready(ready),
        .out_ready(out_ready), .data_out(data_out), .enable_out(enable_out),
        .block_start(block_start), .frame_end(frame_end)
    );

    typedef struct packed {
        logic [23:0] data;
        logic        bs;
        logic        fe;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] pix [NPIX];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    int          outs_done = 0;
    int          first_out_cyc = 0;
    int          last_out_cyc = 0;
    bit          saw_first = 1'b0;
    int          t_last_acc = 0;
    bit          lat_arm = 1'b0;
    bit          prev_stall = 1'b0;
    logic [26:0] prev_out = '0;
    int          lvl_idx = -1;
    logic [23:0] lvl_cap = '0;
    int          base;
    int          guard;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [23:0] shift(input logic [23:0] p);
`ifdef LEVEL_SHIFT_EN
        return {p[23:16] - 8'd128, p[15:8] - 8'd128, p[7:0] - 8'd128};
`else
        return p;
`endif
    endfunction

    task automatic fill_frame();
        for (int n = 0; n < NPIX; n++)
            pix[n] = {8'(n % 16), 8'(n / 16), 8'(n)};
    endtask

    task automatic push_strip(input int s);
        exp_t e;
        for (int bx = 0; bx < W / 8; bx++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) begin
                    e.data = shift(pix[(s * 8 + r) * W + bx * 8 + c]);
                    e.bs   = (r == 0) && (c == 0);
                    e.fe   = (s == H / 8 - 1) && (bx == W / 8 - 1) && (r == 7) && (c == 7);
                    exp_q.push_back(e);
                end
    endtask

    task automatic monitor();
        exp_t e;
        if (prev_stall)
            chk("hold", 32'({enable_out, data_out, block_start, frame_end}), 32'(prev_out));
        prev_stall = enable_out && !out_ready;
        prev_out   = {enable_out, data_out, block_start, frame_end};
        if (enable_out && out_ready) begin
            if (lat_arm) begin
                chk("latency", 32'(cyc - t_last_acc), 32'd2);
                lat_arm = 1'b0;
            end
            if (!saw_first) begin
                first_out_cyc = cyc;
                saw_first     = 1'b1;
            end
            last_out_cyc = cyc;
            if (outs_done == lvl_idx) lvl_cap = data_out;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_beat observed=%0h expected=none", data_out);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("beat", 32'({data_out, block_start, frame_end}), 32'({e.data, e.bs, e.fe}));
            end
            outs_done++;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        monitor();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 0);
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic drive(input int n_stop, input bit arm, input bit fillchk);
        int n = 0;
        int g = 0;
        bit acc;
        while (n < n_stop && g < 4000) begin
            acc     = ready;
            enable  = 1'b1;
            data_in = pix[n];
            if (fillchk) chk("ready_fill", 32'(ready), 32'd1);
            cycle();
            if (acc) begin
                if (arm && n == SPIX - 1) begin
                    t_last_acc = cyc + 1;
                    lat_arm    = 1'b1;
                end
                if (n % SPIX == SPIX - 1) push_strip(n / SPIX);
                n++;
            end
            g++;
        end
        enable = 1'b0;
        chk("input_accepted", 32'(n), 32'(n_stop));
    endtask

    task automatic drain(input string tag);
        int g = 0;
        enable = 1'b0;
        while (exp_q.size() > 0 && g < 2000) begin
            cycle();
            g++;
        end
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        repeat (3) cycle();
        chk({tag, "_idle"}, 32'(enable_out), 32'd0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; data_in = '0; out_ready = 1'b0; rdy_mode = 2;
        #3 rst = 1'b0;
        #2;
        chk("rst_enable_out", 32'(enable_out), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_flags", 32'({block_start, frame_end}), 32'd0);
        repeat (2) cycle();
        rst = 1'b1;
        rdy_mode = 0; out_ready = 1'b1;

        // Ordering with out_ready held high
        fill_frame();
        saw_first = 1'b0;
        drive(NPIX, 1'b1, 1'b0);
        drain("order");
        chk("throughput", 32'(last_out_cyc - first_out_cyc), 32'(NPIX - 1));

        // Backpressure: out_ready one cycle in three
        rdy_mode = 1;
        drive(NPIX, 1'b0, 1'b0);
        drain("backpressure");

        // Both banks full, then dropped inputs while stalled
        rdy_mode = 2; out_ready = 1'b0;
        drive(NPIX, 1'b0, 1'b1);
        chk("ready_full", 32'(ready), 32'd0);
        repeat (8) begin
            enable = 1'b1; data_in = 24'hAAAAAA;
            chk("ready_stalled", 32'(ready), 32'd0);
            cycle();
        end
        rdy_mode = 0; out_ready = 1'b1;
        base = outs_done;
        guard = 0;
        while (outs_done - base < 130 && guard < 600) begin
            chk("ready_release", 32'(ready), 32'(outs_done - base >= SPIX));
            enable  = !ready;
            data_in = 24'hAAAAAA;
            cycle();
            guard++;
        end
        drain("full");

        // Reset in the middle of a strip
        drive(40, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("mid_rst_enable_out", 32'(enable_out), 32'd0);
        chk("mid_rst_data_out", 32'(data_out), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd1);
        prev_stall = 1'b0;
        exp_q.delete();
        repeat (3) cycle();
        rst = 1'b1;
        saw_first = 1'b0;
        drive(NPIX, 1'b1, 1'b0);
        drain("after_reset");
        chk("throughput_after_reset", 32'(last_out_cyc - first_out_cyc), 32'(NPIX - 1));

        // Level-shift reference pixel at position 0
        pix[0]  = 24'h0080FF;
        lvl_idx = outs_done;
        drive(NPIX, 1'b0, 1'b0);
        drain("level");
        chk("level_shift", 32'(lvl_cap), 32'(LVL_EXP));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ycrcb_block_buffer.md
# ycrcb_block_buffer

Raster-to-block reorder buffer placed directly downstream of the RGB-to-YCbCr colour converter. It accepts 24-bit {Cr,Cb,Y} pixels in raster order and stores 8-row strips in two ping-pong banks. It emits each strip as consecutive 8x8 blocks, row-major inside each block, for the DCT stage. Downstream backpressure is supported, and an optional level shift prepares the samples for the DCT.

## Interface
- IMG_WIDTH, 64, pixels per line; must be a multiple of 8 and at least 8
- IMG_HEIGHT, 64, lines per frame; must be a multiple of 8 and at least 8
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-low reset
- enable  in  1  data_in is valid this cycle
- data_in  in  24  pixel: [7:0] Y, [15:8] Cb, [23:16] Cr
- ready  out  1  buffer can accept a pixel this cycle
- out_ready  in  1  downstream accepts data_out this cycle
- data_out  out  24  reordered pixel, same byte layout as data_in
- enable_out  out  1  data_out is valid
- block_start  out  1  data_out is pixel 0 of an 8x8 block
- frame_end  out  1  data_out is the last pixel of the frame

## Operation
- Storage is two banks. Each bank holds 8×IMG_WIDTH entries of 24 bits.
- State registers:
  - wr_bank, rd_bank (1 bit each)
  - bank_full[1:0]
  - write counters: col, row (0..7), strip
  - read counters: bx, r, c, plus a strip counter
- **Write side**
  - ready = !bank_full[wr_bank].
  - A pixel is accepted when enable && ready. It is written to bank wr_bank at address row×IMG_WIDTH+col.
  - On the last pixel of a strip: set bank_full[wr_bank] and toggle wr_bank.
  - enable while ready=0: the pixel is dropped. No state changes.
- **Read FSM**
  - R_IDLE → R_DRAIN when bank_full[rd_bank]=1.
  - In R_DRAIN the read address is r×IMG_WIDTH + bx×8 + c.
  - Order: c counts fastest, then r, then bx (0..IMG_WIDTH/8−1).
  - When the last pixel of the strip is accepted downstream: clear bank_full[rd_bank], toggle rd_bank, return to R_IDLE.
- **Output flags**
  - block_start=1 when r=0 and c=0.
  - frame_end=1 on the last pixel of the last strip. The strip counter then wraps to 0.
- **Simultaneous events**
  - A set and a clear of bank_full on the same edge target different banks; both take effect.
  - If the write side fills a bank on the same edge the read side frees the other, ready stays 1.
- **Reset (any time)**
  - All outputs go to 0 and ready goes to 1.
  - All counters, flags and bank pointers are cleared.
  - Any partial strip is discarded. Memory contents are don't-care.

## Timing
- The bank memory has a registered, 1-cycle read.
- Handshake: a beat transfers when enable_out && out_ready.
- While enable_out=1 and out_ready=0, data_out, block_start and frame_end hold stable. No read beat is lost; an output/skid register is required.
- Latency: the first pixel of a strip appears on data_out 2 cycles after the strip's final input pixel is accepted, provided the output path is idle.
- Throughput: 1 pixel/cycle with out_ready held at 1.
- One idle cycle (enable_out=0) between strips is permitted and is the maximum.
- The writer stalls (ready=0) only when both banks are full.

## Configuration
- LEVEL_SHIFT_EN
  - Defined: each output byte is component − 128 as 8-bit two's complement, i.e. its MSB is inverted. This applies to Y, Cb and Cr.
  - Undefined: output bytes equal the stored input bytes.
  - Storage, ordering and timing are identical in both builds.

## Test plan
- **Ordering.** IMG_WIDTH=16, IMG_HEIGHT=8; input pixel n has Y=n, Cb=n/16, Cr=n%16; out_ready=1.
  - Required: Y sequence 0..7, 16..23, …, 112..119, then 8..15, 24..31, ….
  - block_start on outputs 0 and 64; frame_end on output 127 only.
- **Backpressure.** Same stimulus with out_ready=1 one cycle in three.
  - Required: identical output sequence, with data_out constant across every stalled cycle.
- **Both banks full.** IMG_WIDTH=16, IMG_HEIGHT=16; out_ready=0; enable=1 continuously.
  - Required: ready falls after 256 accepted pixels.
  - Once out_ready=1, ready returns to 1 on the edge after output 127 is accepted.
- **Level shift.** Input Y=0xFF, Cb=0x80, Cr=0x00.
  - With LEVEL_SHIFT_EN: output Y=0x7F, Cb=0x00, Cr=0x80.
  - Without: output unchanged.
- **Reset mid-strip.** Drive rst low after 40 pixels.
  - Required: enable_out=0, data_out=0, ready=1 while in reset.
  - A following full frame reproduces the ordering scenario exactly.
- **Dropped input.** Drive enable=1 with ready=0 and data Y=0xAA.
  - Required: 0xAA never appears on the output and no ordering is disturbed.
